// File: rtl/button_step_pkg.sv
// Shared state encoding and timer sizing for the button step controller.
package button_step_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..max_val without wrapping.
    function automatic int timer_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Accepts a new level only after it has persisted for DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter
    import button_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int               CNT_W    = timer_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             stable_r;

    // Count consecutive mismatching cycles; the last one flips the accepted level.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (din == stable_r) begin
            cnt_r    <= '0;
            stable_r <= stable_r;
        end else if (cnt_r >= CNT_LAST) begin
            cnt_r    <= '0;
            stable_r <= ~stable_r;
        end else begin
            cnt_r    <= cnt_r + 1'b1;
            stable_r <= stable_r;
        end
    end

    assign dout = stable_r;

endmodule

// File: rtl/button_step_ctrl.sv
// Raw button -> 2-flop sync -> debounce -> press FSM emitting one-cycle step pulses.
// Optional hold-to-auto-repeat is compiled in when AUTO_REPEAT_EN is defined.
module button_step_ctrl
    import button_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_raw,
    input  logic       enable,
    output logic       step,
    output logic       pressed,
    output logic [1:0] state_dbg
);

    logic   sync1_r;
    logic   sync2_r;
    logic   stable_s;
    logic   fire_s;
    logic   step_r;
    state_t state_r;
    state_t state_n;

    // Zero-valued timing parameters have no meaningful behaviour; leave a visible marker.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    end

`ifdef AUTO_REPEAT_EN
    localparam int               TMR_MAX_I  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               TMR_W      = timer_w(TMR_MAX_I);
    localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(TMR_MAX_I);
    localparam logic [TMR_W-1:0] TMR_DELAY  = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0] TMR_PERIOD = TMR_W'(REPEAT_PERIOD);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_n;
`endif

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= button_raw;
            sync2_r <= sync1_r;
        end
    end

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .din   (sync2_r),
        .dout  (stable_s)
    );

    // Next-state logic; the timer is loaded with 1 on each step so equality marks the full interval.
    always_comb begin
        state_n = state_r;
        fire_s  = 1'b0;
`ifdef AUTO_REPEAT_EN
        timer_n = (timer_r == TMR_MAX) ? timer_r : timer_r + TMR_ONE;
`endif
        case (state_r)
            IDLE: begin
                if (stable_s) begin
                    fire_s  = 1'b1;
                    state_n = HELD;
`ifdef AUTO_REPEAT_EN
                    timer_n = TMR_ONE;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            HELD: begin
                // Release wins over a coincident timer expiry.
                if (!stable_s) begin
                    state_n = IDLE;
`ifdef AUTO_REPEAT_EN
                end else if (timer_r == TMR_DELAY) begin
                    fire_s  = 1'b1;
                    state_n = REPEAT;
                    timer_n = TMR_ONE;
`endif
                end else begin
                    state_n = HELD;
                end
            end
            REPEAT: begin
`ifdef AUTO_REPEAT_EN
                if (!stable_s) begin
                    state_n = IDLE;
                end else if (timer_r == TMR_PERIOD) begin
                    fire_s  = 1'b1;
                    state_n = REPEAT;
                    timer_n = TMR_ONE;
                end else begin
                    state_n = REPEAT;
                end
`else
                state_n = IDLE;
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state and the gated, registered step pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            step_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            step_r  <= fire_s & enable;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Saturating repeat timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_n;
        end
    end
`endif

    assign step      = step_r;
    assign pressed   = stable_s;
    assign state_dbg = state_r;

endmodule

// File: tb/tb_button_step_ctrl.sv
// Self-checking bench for button_step_ctrl against a cycle-level behavioural model.
module tb_button_step_ctrl;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       button_raw = 1'b0;
    logic       enable = 1'b1;
    logic       step;
    logic       pressed;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Behavioural model: raw seen two edges late, level accepted after DEB equal samples,
    // steps at press start and then at t0+DLY+k*PER while still pressed.
    bit         m_s1, m_s2, m_stable, m_in_press;
    int         m_run, m_t0, cyc;
    bit         exp_step, exp_pressed;
    logic [1:0] exp_state;
    int         m_steps;

    button_step_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_PERIOD   (PER)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .button_raw (button_raw),
        .enable     (enable),
        .step       (step),
        .pressed    (pressed),
        .state_dbg  (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic tick();
        bit stable_before;
        bit fire;
        int d;
        @(posedge clock);
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_run = 0; m_in_press = 0;
            exp_step = 0; exp_pressed = 0; exp_state = 2'd0;
        end else begin
            stable_before = m_stable;
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == DEB) begin
                    m_stable = !m_stable;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = button_raw;
            fire = 0;
            if (!stable_before) begin
                m_in_press = 0;
                exp_state = 2'd0;
            end else begin
                if (!m_in_press) begin
                    m_in_press = 1;
                    m_t0 = cyc;
                    fire = 1;
                end else begin
                    d = cyc - m_t0;
                    if (AUTO && (d == DLY || (d > DLY && (d - DLY) % PER == 0))) fire = 1;
                end
                exp_state = (AUTO && (cyc - m_t0) >= DLY) ? 2'd2 : 2'd1;
            end
            exp_step = fire && enable;
            exp_pressed = m_stable;
            if (exp_step) m_steps++;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; button_raw = 1'b1; enable = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({step, pressed, state_dbg} !== 4'b0000)
            begin errors++; $display("FAIL reset_state: got %b want 0000", {step, pressed, state_dbg}); end
        button_raw = 1'b0;
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_clean_press();
        int first = -1, fall = -1, dut_n = 0, m0;
        m0 = m_steps;
        button_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                begin errors++; $display("FAIL clean_cycle: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            if (step) begin dut_n++; if (first < 0) first = i; end
        end
        button_raw = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                begin errors++; $display("FAIL clean_release: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            if (step) dut_n++;
            if (!pressed && fall < 0) fall = i;
        end
        checks++;
        if (first !== 7) begin errors++; $display("FAIL clean_latency: got %0d want 7", first); end
        checks++;
        if (fall !== 6) begin errors++; $display("FAIL release_latency: got %0d want 6", fall); end
        checks++;
        if (dut_n !== m_steps - m0) begin errors++; $display("FAIL clean_count: got %0d want %0d", dut_n, m_steps - m0); end
`ifndef AUTO_REPEAT_EN
        checks++;
        if (dut_n !== 1) begin errors++; $display("FAIL clean_single: got %0d want 1", dut_n); end
`endif
    endtask

    task automatic test_bounce();
        int bounce_steps = 0, first = -1;
        for (int i = 0; i < 20; i++) begin
            button_raw = ((i / 2) % 2) == 0;
            tick();
            checks++;
            if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                begin errors++; $display("FAIL bounce_cycle: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            if (step) bounce_steps++;
        end
        checks++;
        if (bounce_steps !== 0) begin errors++; $display("FAIL bounce_quiet: got %0d steps want 0", bounce_steps); end
        button_raw = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                begin errors++; $display("FAIL bounce_hold: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            if (step && first < 0) first = i;
        end
        checks++;
        if (first !== 7) begin errors++; $display("FAIL bounce_latency: got %0d want 7", first); end
        button_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random_bounce();
        int run;
        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < 6; b++) begin
                button_raw = ~button_raw;
                run = $urandom_range(DEB - 1, 1);
                for (int k = 0; k < run; k++) begin
                    tick();
                    checks++;
                    if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                        begin errors++; $display("FAIL rbounce_cycle: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
                end
            end
            button_raw = 1'b1;
            run = $urandom_range(30, 8);
            for (int k = 0; k < run; k++) begin
                tick();
                checks++;
                if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                    begin errors++; $display("FAIL rbounce_hold: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            end
            button_raw = 1'b0;
            repeat (10) tick();
        end
    endtask

    task automatic test_enable();
        int dut_n = 0;
        enable = 1'b0;
        button_raw = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 13) enable = 1'b1;
            tick();
            checks++;
            if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                begin errors++; $display("FAIL enable_cycle: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            if (step) dut_n++;
            if (i == 6) begin
                checks++;
                if (pressed !== 1'b1) begin errors++; $display("FAIL enable_pressed: got %b want 1", pressed); end
            end
            if (i == 7) begin
                checks++;
                if (state_dbg !== 2'd1) begin errors++; $display("FAIL enable_state: got %0d want 1", state_dbg); end
            end
        end
        checks++;
        if (dut_n !== 0) begin errors++; $display("FAIL enable_suppress: got %0d steps want 0", dut_n); end
        button_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_hold();
        int first = -1;
        button_raw = 1'b1;
        repeat (12) tick();
        checks++;
        if (state_dbg !== exp_state) begin errors++; $display("FAIL midhold_pre: got %0d want %0d", state_dbg, exp_state); end
        reset = 1'b1;
        tick();
        checks++;
        if ({step, pressed, state_dbg} !== 4'b0000)
            begin errors++; $display("FAIL midhold_reset: got %b want 0000", {step, pressed, state_dbg}); end
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                begin errors++; $display("FAIL midhold_cycle: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            if (step && first < 0) first = i;
        end
        checks++;
        if (first !== 7) begin errors++; $display("FAIL midhold_latency: got %0d want 7", first); end
        button_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_long_hold();
        int dut_n = 0, m0;
        bit saw_repeat = 0;
        m0 = m_steps;
        button_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                begin errors++; $display("FAIL hold_cycle: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            if (step) dut_n++;
            if (state_dbg == 2'd2) saw_repeat = 1;
        end
        button_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                begin errors++; $display("FAIL hold_release: got %b want %b", {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            if (step) dut_n++;
        end
        checks++;
        if (dut_n !== m_steps - m0) begin errors++; $display("FAIL hold_count: got %0d want %0d", dut_n, m_steps - m0); end
`ifndef AUTO_REPEAT_EN
        checks++;
        if (dut_n !== 1 || saw_repeat) begin errors++; $display("FAIL hold_single: got %0d steps repeat=%b want 1 steps repeat=0", dut_n, saw_repeat); end
`else
        checks++;
        if (!saw_repeat) begin errors++; $display("FAIL hold_repeat: got repeat=%b want 1", saw_repeat); end
`endif
    endtask

    task automatic test_random();
        int run;
        for (int s = 0; s < 90; s++) begin
            button_raw = $urandom_range(1, 0);
            run = $urandom_range(15, 1);
            for (int k = 0; k < run; k++) begin
                if ($urandom_range(7, 0) == 0) enable = ~enable;
                reset = ($urandom_range(199, 0) == 0);
                tick();
                checks++;
                if ({step, pressed, state_dbg} !== {exp_step, exp_pressed, exp_state})
                    begin errors++; $display("FAIL random_cycle %0d: got %b want %b", cyc, {step, pressed, state_dbg}, {exp_step, exp_pressed, exp_state}); end
            end
        end
        reset = 1'b0;
        enable = 1'b1;
        button_raw = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        cyc = 0;
        m_steps = 0;
        m_t0 = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_random_bounce();
        test_enable();
        test_reset_mid_hold();
        test_long_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
